filter_border_pad: RTL and testbench
====================================

// Module: filter_border_pad
// PURPOSE
//   Sits between demosaic and the KxK filter. Turns a raster RGB stream of WIDTH x HEIGHT
//   into a padded stream of (WIDTH+2B) x (HEIGHT+2B) pixels, where B = (KERNEL_SIZE-1)/2.
//   Pad style is chosen per frame: zero, constant or horizontal edge-replicate.
//   Both sides use valid/ready handshakes, so the filter can apply backpressure.
// PARAMETERS
//   WIDTH        320  active pixels per input row
//   HEIGHT       240  active rows per input frame
//   KERNEL_SIZE  3    filter kernel size; must be odd and >= 3
//   CHANNELS     3    colour channels per pixel
//   DW           8    bits per channel; pixel width is PW = CHANNELS*DW
// PORTS
//   clk        in   1      clock
//   reset      in   1      asynchronous, active-low reset
//   newFrame   in   1      start-of-frame pulse; ignored unless the FSM is in IDLE
//   padMode    in   2      0=zero, 1=constant, 2=replicate, 3=reserved (treated as 0); sampled on newFrame
//   padValue   in   PW     pad value for constant mode; sampled on newFrame
//   iValid     in   1      upstream pixel valid
//   iReady     out  1      block accepts iData this cycle
//   iData      in   PW     upstream pixel, channel 0 in the MSBs
//   oValid     out  1      padded pixel valid
//   oReady     in   1      downstream accepts oData
//   oData      out  PW     padded pixel
//   oBorder    out  1      qualifies oData: 1 = pad pixel, 0 = real pixel
//   oDone      out  1      one-cycle pulse after the last padded pixel is accepted
// BEHAVIOUR
//   Reset (reset=0, asynchronous)
//   - FSM goes to IDLE; counters clear; latched mode and value clear.
//   - Outputs: oValid=0, oData=0, oBorder=0, oDone=0, iReady=0.
//   Output register
//   - oData, oValid and oBorder are registered.
//   - The register advances when (!oValid || oReady); otherwise it holds stable.
//   - A real pixel appears on oData 1 cycle after its iValid&&iReady transfer.
//   FSM states: IDLE, TOP, LEFT, DATA, RIGHT, BOTTOM, DONE
//   - Counters: x (column within the current segment) and y (padded row index).
//   - IDLE -> TOP on newFrame; latch padMode and padValue; x=0, y=0.
//   - TOP: emit B full rows of WIDTH+2B pad pixels -> LEFT.
//   - LEFT: emit B pad pixels -> DATA.
//   - DATA: consume WIDTH pixels, iReady = (output register can advance) -> RIGHT.
//   - RIGHT: emit B pad pixels.
//     - If more active rows remain -> LEFT.
//     - After the HEIGHT-th active row -> BOTTOM.
//   - BOTTOM: emit B full pad rows -> DONE.
//   - DONE: pulse oDone for 1 cycle -> IDLE.
//   - iReady=0 in every state except DATA.
//   Pad value
//   - Zero mode: 0.
//   - Constant mode: the latched padValue.
//   - Replicate mode, TOP/BOTTOM rows: 0.
//   - Replicate mode, LEFT: the current iData. The block waits for iValid and
//     peeks iData without consuming it; upstream must hold iData stable while iValid && !iReady.
//   - Replicate mode, RIGHT: a register holding the last pixel consumed in DATA.
//   Timing and boundaries
//   - In every state, a pad pixel or pixel transfer happens only when the output register can advance.
//   - Total output per frame = (WIDTH+2B)*(HEIGHT+2B) beats; a beat is an oValid&&oReady transfer.
//   - oReady held low: all state and counters freeze; no pixel is dropped or duplicated.
//   - iValid gaps in DATA or LEFT: oValid drops to 0 and the FSM waits.
//   - newFrame outside IDLE, including in the same cycle as oDone: ignored.
//   - Extra upstream pixels after a frame: not accepted, because iReady=0.
//   - Reset mid-frame: output stops immediately; the next frame needs a fresh newFrame.
// TESTING
//   (WIDTH=4, HEIGHT=3, K=3, CHANNELS=3, DW=8 unless noted)
//   1) Zero mode, pixels 0x010101..0x0C0C0C, oReady=1
//      -> 30 beats. Rows 0 and 4 are all-zero with oBorder=1. Row 1 is
//      0,01,02,03,04,0. oDone fires 1 cycle after beat 30.
//   2) Constant mode, padValue=0xFF00FF
//      -> all 18 pad beats equal 0xFF00FF; the 12 data beats are unchanged and in order.
//   3) Replicate mode
//      -> row 1 is 01,01,02,03,04,04; rows 0 and 4 are zero.
//   4) Random oReady (50%) and random iValid gaps
//      -> the beat sequence is identical to test 1; oData is stable while oValid && !oReady.
//   5) Pulse reset after output beat 10, then newFrame
//      -> all outputs 0 immediately; the new frame outputs 30 beats from the start.
//   6) K=5, WIDTH=4, HEIGHT=2
//      -> 8x6 = 48 beats; 2 pad pixels on each side of a row; 2 top and 2 bottom pad rows.

Source files
------------

// File: rtl/filter_border_pad_if.sv
// Pixel handshake bundle for filter_border_pad: upstream pixel input, padded output and frame-done pulse.
// slave is the padding block's view; master is the surrounding pipeline's view.
interface filter_border_pad_if #(
  parameter int unsigned PW = 24
);
  logic          iValid;
  logic          iReady;
  logic [PW-1:0] iData;
  logic          oValid;
  logic          oReady;
  logic [PW-1:0] oData;
  logic          oBorder;
  logic          oDone;

  modport master (
    output iValid, iData, oReady,
    input  iReady, oValid, oData, oBorder, oDone
  );

  modport slave (
    input  iValid, iData, oReady,
    output iReady, oValid, oData, oBorder, oDone
  );
endinterface

// File: rtl/filter_border_pad.sv
// Wraps a WIDTH x HEIGHT raster pixel stream with a B-pixel border (B = (KERNEL_SIZE-1)/2)
// in zero, constant or horizontal edge-replicate style, with valid/ready on both sides.
module filter_border_pad #(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned DW          = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     newFrame,
  input  logic [1:0]               padMode,
  input  logic [CHANNELS*DW-1:0]   padValue,
  filter_border_pad_if.slave       bus
);

  localparam int unsigned PW    = CHANNELS * DW;
  localparam int unsigned B     = (KERNEL_SIZE - 1) / 2;
  localparam int unsigned PAD_W = WIDTH + 2 * B;
  localparam int unsigned PAD_H = HEIGHT + 2 * B;
  localparam int unsigned XW    = $clog2(PAD_W + 1);
  localparam int unsigned YW    = $clog2(PAD_H + 1);

  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_REPL  = 2'd2;

  typedef enum logic [2:0] {IDLE, TOP, LEFT, DATA, RIGHT, BOTTOM, DONE} state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    mode;
  logic [PW-1:0] value;
  logic [PW-1:0] last_pix;

  logic          adv;
  logic          repl;
  logic [PW-1:0] fill;
  logic          x_row_end;
  logic          x_b_end;
  logic          x_w_end;

  // Output register may load a new beat when empty or being drained this cycle.
  assign adv       = !bus.oValid || bus.oReady;
  assign repl      = (mode == MODE_REPL);
  // Reserved mode 3 falls through to zero fill.
  assign fill      = (mode == MODE_CONST) ? value : '0;
  assign x_row_end = (x == XW'(PAD_W - 1));
  assign x_b_end   = (x == XW'(B - 1));
  assign x_w_end   = (x == XW'(WIDTH - 1));

  assign bus.iReady = (state == DATA) && adv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      mode        <= '0;
      value       <= '0;
      last_pix    <= '0;
      bus.oValid  <= 1'b0;
      bus.oData   <= '0;
      bus.oBorder <= 1'b0;
      bus.oDone   <= 1'b0;
    end else begin
      bus.oDone <= 1'b0;
      case (state)
        IDLE: begin
          // A newFrame coinciding with the previous frame's done pulse is dropped.
          if (newFrame && !bus.oDone) begin
            mode  <= padMode;
            value <= padValue;
            x     <= '0;
            y     <= '0;
            state <= TOP;
          end
        end
        TOP, BOTTOM: begin
          if (adv) begin
            bus.oValid  <= 1'b1;
            bus.oBorder <= 1'b1;
            bus.oData   <= fill;
            if (x_row_end) begin
              x <= '0;
              y <= y + YW'(1);
              if (state == TOP && y == YW'(B - 1))
                state <= LEFT;
              else if (state == BOTTOM && y == YW'(PAD_H - 1))
                state <= DONE;
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        LEFT: begin
          if (adv) begin
            // Replicate peeks the row's first pixel, so it must wait for it.
            if (repl && !bus.iValid) begin
              bus.oValid <= 1'b0;
            end else begin
              bus.oValid  <= 1'b1;
              bus.oBorder <= 1'b1;
              bus.oData   <= repl ? bus.iData : fill;
              if (x_b_end) begin
                x     <= '0;
                state <= DATA;
              end else begin
                x <= x + XW'(1);
              end
            end
          end
        end
        DATA: begin
          if (adv) begin
            if (bus.iValid) begin
              bus.oValid  <= 1'b1;
              bus.oBorder <= 1'b0;
              bus.oData   <= bus.iData;
              last_pix    <= bus.iData;
              if (x_w_end) begin
                x     <= '0;
                state <= RIGHT;
              end else begin
                x <= x + XW'(1);
              end
            end else begin
              bus.oValid <= 1'b0;
            end
          end
        end
        RIGHT: begin
          if (adv) begin
            bus.oValid  <= 1'b1;
            bus.oBorder <= 1'b1;
            bus.oData   <= repl ? last_pix : fill;
            if (x_b_end) begin
              x     <= '0;
              y     <= y + YW'(1);
              state <= (y == YW'(B + HEIGHT - 1)) ? BOTTOM : LEFT;
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        DONE: begin
          // Wait for the final beat to drain before signalling completion.
          if (adv) begin
            bus.oValid <= 1'b0;
            bus.oDone  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_border_pad.sv
// Directed bench for filter_border_pad: 4x3 frames with a 3x3 kernel and a 4x2 frame with a 5x5 kernel.
module tb_filter_border_pad;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        newf;
  logic [1:0]  mode;
  logic [23:0] pval;
  logic        iv;
  logic [23:0] id;
  logic        ordy;

  always #5 clk = ~clk;

  filter_border_pad_if #(.PW(24)) bus3 ();
  filter_border_pad_if #(.PW(24)) bus5 ();

  assign bus3.iValid = iv & ~sel;
  assign bus3.iData  = id;
  assign bus3.oReady = ordy;
  assign bus5.iValid = iv & sel;
  assign bus5.iData  = id;
  assign bus5.oReady = ordy;

  filter_border_pad #(.WIDTH(4), .HEIGHT(3), .KERNEL_SIZE(3), .CHANNELS(3), .DW(8)) dut3 (
    .clk(clk), .reset(reset), .newFrame(newf & ~sel), .padMode(mode), .padValue(pval), .bus(bus3)
  );

  filter_border_pad #(.WIDTH(4), .HEIGHT(2), .KERNEL_SIZE(5), .CHANNELS(3), .DW(8)) dut5 (
    .clk(clk), .reset(reset), .newFrame(newf & sel), .padMode(mode), .padValue(pval), .bus(bus5)
  );

  logic        o_valid, o_border, o_done, i_ready;
  logic [23:0] o_data;
  assign o_valid  = sel ? bus5.oValid  : bus3.oValid;
  assign o_border = sel ? bus5.oBorder : bus3.oBorder;
  assign o_done   = sel ? bus5.oDone   : bus3.oDone;
  assign o_data   = sel ? bus5.oData   : bus3.oData;
  assign i_ready  = sel ? bus5.iReady  : bus3.iReady;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] cap_d [0:63];
  logic        cap_b [0:63];
  int          nbeats, done_cyc, last_cyc, stab_err;

  function automatic logic [23:0] pix(input int k);
    return {3{8'(k)}};
  endfunction

  // Reference: {border, data} of padded beat idx for a w x h frame with border b.
  function automatic logic [24:0] model(input int w, input int h, input int b,
                                        input logic [1:0] m, input logic [23:0] pv, input int idx);
    int pw, r, c, ar;
    logic [23:0] f;
    pw = w + 2 * b;
    r  = idx / pw;
    c  = idx % pw;
    f  = (m == 2'd1) ? pv : 24'h0;
    if (r < b || r >= b + h) return {1'b1, f};
    ar = r - b;
    if (c < b)      return {1'b1, (m == 2'd2) ? pix(ar * w + 1) : f};
    if (c >= b + w) return {1'b1, (m == 2'd2) ? pix(ar * w + w) : f};
    return {1'b0, pix(ar * w + (c - b) + 1)};
  endfunction

  // Starts a frame and captures output beats until oDone, the cycle budget, or stop_after beats.
  task automatic run_frame(input bit s, input logic [1:0] m, input logic [23:0] pv,
                           input bit rnd, input int stop_after, input bit nf_on_done);
    int          src, cyc;
    bit          hold_v;
    logic [23:0] hold_d;
    src = 1; cyc = 0; hold_v = 0; hold_d = '0;
    nbeats = 0; done_cyc = -1; last_cyc = -1; stab_err = 0;
    @(negedge clk);
    sel = s; mode = m; pval = pv; iv = 1'b0; ordy = 1'b1; newf = 1'b1;
    @(negedge clk);
    newf = 1'b0;
    while (cyc < 3000 && done_cyc < 0 && !(stop_after > 0 && nbeats >= stop_after)) begin
      @(negedge clk);
      iv   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      id   = pix(src);
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (hold_v && o_data !== hold_d) stab_err++;
      hold_v = o_valid && !ordy;
      hold_d = o_data;
      if (o_valid && ordy) begin
        if (nbeats < 64) begin
          cap_d[nbeats] = o_data;
          cap_b[nbeats] = o_border;
        end
        nbeats++;
        last_cyc = cyc;
      end
      if (iv && i_ready) src++;
      if (o_done) begin
        done_cyc = cyc;
        if (nf_on_done) newf = 1'b1;
      end
      cyc++;
    end
    ordy = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; sel = 1'b0; newf = 1'b0; mode = '0; pval = '0; iv = 1'b0; id = '0; ordy = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus3.oValid, bus3.oBorder, bus3.oDone, bus3.iReady, bus3.oData} !== 28'h0) begin
      errors++; $display("FAIL reset_dut3 got %h exp 0", {bus3.oValid, bus3.oBorder, bus3.oDone, bus3.iReady, bus3.oData});
    end
    checks++;
    if ({bus5.oValid, bus5.oBorder, bus5.oDone, bus5.iReady, bus5.oData} !== 28'h0) begin
      errors++; $display("FAIL reset_dut5 got %h exp 0", {bus5.oValid, bus5.oBorder, bus5.oDone, bus5.iReady, bus5.oData});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [23:0] r1 [0:5];
    logic        b1 [0:5];
    logic [24:0] e;
    r1 = '{24'h0, 24'h010101, 24'h020202, 24'h030303, 24'h040404, 24'h0};
    b1 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_frame(1'b0, 2'd0, 24'h0, 1'b0, 0, 1'b0);
    checks++;
    if (nbeats !== 30) begin errors++; $display("FAIL zero_beats got %0d exp 30", nbeats); end
    for (int i = 0; i < 30 && i < nbeats; i++) begin
      e = model(4, 3, 1, 2'd0, 24'h0, i);
      checks++;
      if ({cap_b[i], cap_d[i]} !== e) begin
        errors++; $display("FAIL zero_beat%0d got %h exp %h", i, {cap_b[i], cap_d[i]}, e);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({cap_b[6 + i], cap_d[6 + i]} !== {b1[i], r1[i]}) begin
        errors++; $display("FAIL zero_row1_%0d got %h exp %h", i, {cap_b[6 + i], cap_d[6 + i]}, {b1[i], r1[i]});
      end
    end
    checks++;
    if (done_cyc < 0 || done_cyc !== last_cyc + 1) begin
      errors++; $display("FAIL zero_done got cyc %0d exp %0d", done_cyc, last_cyc + 1);
    end
  endtask

  task automatic test_constant();
    int npad;
    logic [24:0] e;
    npad = 0;
    run_frame(1'b0, 2'd1, 24'hFF00FF, 1'b0, 0, 1'b0);
    checks++;
    if (nbeats !== 30) begin errors++; $display("FAIL const_beats got %0d exp 30", nbeats); end
    for (int i = 0; i < 30 && i < nbeats; i++) begin
      e = model(4, 3, 1, 2'd1, 24'hFF00FF, i);
      if (cap_b[i] === 1'b1 && cap_d[i] === 24'hFF00FF) npad++;
      checks++;
      if ({cap_b[i], cap_d[i]} !== e) begin
        errors++; $display("FAIL const_beat%0d got %h exp %h", i, {cap_b[i], cap_d[i]}, e);
      end
    end
    checks++;
    if (npad !== 18) begin errors++; $display("FAIL const_pad_count got %0d exp 18", npad); end
  endtask

  task automatic test_replicate();
    logic [23:0] r1 [0:5];
    logic [23:0] r3 [0:5];
    logic [24:0] e;
    r1 = '{24'h010101, 24'h010101, 24'h020202, 24'h030303, 24'h040404, 24'h040404};
    r3 = '{24'h090909, 24'h090909, 24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0C0C0C};
    run_frame(1'b0, 2'd2, 24'h123456, 1'b0, 0, 1'b0);
    checks++;
    if (nbeats !== 30) begin errors++; $display("FAIL repl_beats got %0d exp 30", nbeats); end
    for (int i = 0; i < 30 && i < nbeats; i++) begin
      e = model(4, 3, 1, 2'd2, 24'h123456, i);
      checks++;
      if ({cap_b[i], cap_d[i]} !== e) begin
        errors++; $display("FAIL repl_beat%0d got %h exp %h", i, {cap_b[i], cap_d[i]}, e);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap_d[6 + i] !== r1[i] || cap_d[18 + i] !== r3[i]) begin
        errors++; $display("FAIL repl_rows_%0d got %h/%h exp %h/%h", i, cap_d[6 + i], cap_d[18 + i], r1[i], r3[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [24:0] e;
    for (int rep = 0; rep < 3; rep++) begin
      run_frame(1'b0, 2'd0, 24'h0, 1'b1, 0, 1'b0);
      checks++;
      if (nbeats !== 30) begin errors++; $display("FAIL rand_beats got %0d exp 30", nbeats); end
      for (int i = 0; i < 30 && i < nbeats; i++) begin
        e = model(4, 3, 1, 2'd0, 24'h0, i);
        checks++;
        if ({cap_b[i], cap_d[i]} !== e) begin
          errors++; $display("FAIL rand_beat%0d got %h exp %h", i, {cap_b[i], cap_d[i]}, e);
        end
      end
      checks++;
      if (stab_err !== 0) begin errors++; $display("FAIL rand_stable got %0d exp 0", stab_err); end
      checks++;
      if (done_cyc < 0 || done_cyc !== last_cyc + 1) begin
        errors++; $display("FAIL rand_done got cyc %0d exp %0d", done_cyc, last_cyc + 1);
      end
    end
  endtask

  task automatic test_done_newframe();
    logic [24:0] e;
    run_frame(1'b0, 2'd3, 24'hABCDEF, 1'b0, 0, 1'b1);
    checks++;
    if (nbeats !== 30) begin errors++; $display("FAIL resv_beats got %0d exp 30", nbeats); end
    for (int i = 0; i < 30 && i < nbeats; i++) begin
      e = model(4, 3, 1, 2'd0, 24'h0, i);
      checks++;
      if ({cap_b[i], cap_d[i]} !== e) begin
        errors++; $display("FAIL resv_beat%0d got %h exp %h", i, {cap_b[i], cap_d[i]}, e);
      end
    end
    @(negedge clk);
    newf = 1'b0; iv = 1'b1; id = 24'h777777;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if ({o_valid, i_ready, o_done} !== 3'b000) begin
        errors++; $display("FAIL idle_after_done%0d got %b exp 000", i, {o_valid, i_ready, o_done});
      end
      @(negedge clk);
    end
    iv = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [24:0] e;
    run_frame(1'b0, 2'd0, 24'h0, 1'b0, 10, 1'b0);
    checks++;
    if (nbeats !== 10) begin errors++; $display("FAIL mid_beats got %0d exp 10", nbeats); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus3.oValid, bus3.oBorder, bus3.oDone, bus3.iReady, bus3.oData} !== 28'h0) begin
      errors++; $display("FAIL mid_reset_outputs got %h exp 0", {bus3.oValid, bus3.oBorder, bus3.oDone, bus3.iReady, bus3.oData});
    end
    @(negedge clk);
    reset = 1'b1;
    iv = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus3.oValid !== 1'b0) begin errors++; $display("FAIL mid_no_autostart got %b exp 0", bus3.oValid); end
    run_frame(1'b0, 2'd0, 24'h0, 1'b0, 0, 1'b0);
    checks++;
    if (nbeats !== 30) begin errors++; $display("FAIL mid_new_beats got %0d exp 30", nbeats); end
    for (int i = 0; i < 30 && i < nbeats; i++) begin
      e = model(4, 3, 1, 2'd0, 24'h0, i);
      checks++;
      if ({cap_b[i], cap_d[i]} !== e) begin
        errors++; $display("FAIL mid_beat%0d got %h exp %h", i, {cap_b[i], cap_d[i]}, e);
      end
    end
  endtask

  task automatic test_k5();
    logic [23:0] r2 [0:7];
    logic [24:0] e;
    r2 = '{24'h010101, 24'h010101, 24'h010101, 24'h020202,
           24'h030303, 24'h040404, 24'h040404, 24'h040404};
    run_frame(1'b1, 2'd2, 24'h0, 1'b0, 0, 1'b0);
    checks++;
    if (nbeats !== 48) begin errors++; $display("FAIL k5_beats got %0d exp 48", nbeats); end
    for (int i = 0; i < 48 && i < nbeats; i++) begin
      e = model(4, 2, 2, 2'd2, 24'h0, i);
      checks++;
      if ({cap_b[i], cap_d[i]} !== e) begin
        errors++; $display("FAIL k5_beat%0d got %h exp %h", i, {cap_b[i], cap_d[i]}, e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_d[16 + i] !== r2[i]) begin
        errors++; $display("FAIL k5_row2_%0d got %h exp %h", i, cap_d[16 + i], r2[i]);
      end
    end
    checks++;
    if (done_cyc < 0 || done_cyc !== last_cyc + 1) begin
      errors++; $display("FAIL k5_done got cyc %0d exp %0d", done_cyc, last_cyc + 1);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_constant();
    test_replicate();
    test_random();
    test_done_newframe();
    test_reset_mid();
    test_k5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
